// File: rtl/seven_seg_frame_renderer.sv
// Renders DIGITS seven-segment glyphs as SSD1306 page bytes, page-major, one byte per accepted cycle.
// First byte is valid the edge after start is latched; outputs hold while ready_in is low.
module seven_seg_frame_renderer #(
  parameter int DIGITS  = 6,
  parameter int DIGIT_W = 21,
  parameter int PAGES   = 4,
  parameter int SEG_T   = 4,
  parameter int GAP     = 4
) (
  input  logic                                          clk_in,
  input  logic                                          reset_n_in,
  input  logic                                          start_in,
  input  logic [DIGITS*8-1:0]                           digits_in,
  output logic                                          busy_out,
  output logic [7:0]                                    data_out,
  output logic                                          valid_out,
  input  logic                                          ready_in,
  output logic                                          last_out,
  output logic [$clog2(PAGES)-1:0]                      page_out,
  output logic [$clog2(DIGITS*(DIGIT_W+GAP))-1:0]       column_out
);

  localparam int PITCH = DIGIT_W + GAP;
  localparam int COLS  = DIGITS * PITCH;
  localparam int H     = 8 * PAGES;
  localparam int HALF  = H / 2;
  localparam int G0    = HALF - SEG_T / 2;
  localparam int PW    = $clog2(PAGES);
  localparam int CW    = $clog2(COLS);
  localparam int XW    = $clog2(PITCH);
  localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(PITCH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if (!(DIGIT_W >= 2*SEG_T+1 && PAGES >= 2 && GAP >= SEG_T && SEG_T >= 1)) begin : g_bad_params
    $error("seven_seg_frame_renderer: illegal parameter combination");
  end

  logic [0:0]          state_q, state_d;
  logic [PW-1:0]       page_q, page_d;
  logic [CW-1:0]       col_q, col_d;
  logic [XW-1:0]       x_q, x_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [DIGITS*8-1:0] digits_q, digits_d;
  logic [7:0]          cur_seg;
  logic [7:0]          pix_byte;
  logic                run;
  logic                last;

  // x is the column within the digit cell, y the absolute row; segments are {dp,g,f,e,d,c,b,a}
  function automatic logic pixel_on(input logic [7:0] s, input int x, input int y);
    logic hx, lx, rx, px;
    hx = (x >= SEG_T) && (x <= DIGIT_W - SEG_T - 1);
    lx = (x <= SEG_T - 1);
    rx = (x >= DIGIT_W - SEG_T) && (x <= DIGIT_W - 1);
    px = (x >= DIGIT_W) && (x <= DIGIT_W + SEG_T - 1);
    return (s[0] && hx && (y <= SEG_T - 1))
        || (s[6] && hx && (y >= G0) && (y <= G0 + SEG_T - 1))
        || (s[3] && hx && (y >= H - SEG_T))
        || (s[5] && lx && (y <= HALF - 1))
        || (s[4] && lx && (y >= HALF))
        || (s[1] && rx && (y <= HALF - 1))
        || (s[2] && rx && (y >= HALF))
        || (s[7] && px && (y >= H - SEG_T));
  endfunction

  assign run  = (state_q == RUN);
  assign last = run && (page_q == PAGE_LAST) && (col_q == COL_LAST);

  always_comb begin
    cur_seg = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q == DW'(k)) cur_seg = digits_q[8*k +: 8];
    end
  end

  always_comb begin
    pix_byte = '0;
    for (int b = 0; b < 8; b++) begin
      pix_byte[b] = pixel_on(cur_seg, 32'(x_q), 32'(page_q) * 8 + b);
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    col_d    = col_q;
    x_d      = x_q;
    dig_d    = dig_q;
    digits_d = digits_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d  = RUN;
          digits_d = digits_in;
          page_d   = '0;
          col_d    = '0;
          x_d      = '0;
          dig_d    = '0;
        end
      end
      RUN: begin
        if (ready_in) begin
          if (last) begin
            state_d = IDLE;
            page_d  = '0;
            col_d   = '0;
            x_d     = '0;
            dig_d   = '0;
          end else if (col_q == COL_LAST) begin
            col_d  = '0;
            x_d    = '0;
            dig_d  = '0;
            page_d = page_q + PW'(1);
          end else begin
            col_d = col_q + CW'(1);
            if (x_q == X_LAST) begin
              x_d   = '0;
              dig_d = dig_q + DW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      page_q   <= '0;
      col_q    <= '0;
      x_q      <= '0;
      dig_q    <= '0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      col_q    <= col_d;
      x_q      <= x_d;
      dig_q    <= dig_d;
      digits_q <= digits_d;
    end
  end

  assign busy_out   = run;
  assign valid_out  = run;
  assign last_out   = last;
  assign data_out   = run ? pix_byte : 8'h00;
  assign page_out   = page_q;
  assign column_out = col_q;

endmodule
